// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared constants, op encodings and FSM states for muldiv_unit
// Rev 1.0
// ============================================================================
package muldiv_pkg;

  localparam int unsigned c_ITERS = 32;

  localparam logic [1:0] c_OP_MULT  = 2'b00;
  localparam logic [1:0] c_OP_MULTU = 2'b01;
  localparam logic [1:0] c_OP_DIV   = 2'b10;
  localparam logic [1:0] c_OP_DIVU  = 2'b11;

  localparam logic [31:0] c_DIVZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// muldiv_signfix : combinational conditional two's-complement negate
// Rev 1.0
// ============================================================================
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative 32-cycle MULT/MULTU/DIV/DIVU with HI/LO registers.
// Divide datapath compiled in only when MULDIV_DIV_EN is defined.
// Rev 1.0
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WeHi,
  input  logic             WeLo,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [4:0]           r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_neg_res;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_last;

  assign w_signed = op_is_signed(Op);
  assign w_last   = (r_cnt == 5'(c_ITERS - 1));

  muldiv_signfix #(.W(WIDTH)) u_fix_a (
    .i_val (A),
    .i_neg (w_signed & A[WIDTH-1]),
    .o_val (w_abs_a)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_b (
    .i_val (B),
    .i_neg (w_signed & B[WIDTH-1]),
    .o_val (w_abs_b)
  );

  // Shift-add: the upper half accumulates, the multiplier drains out of bit 0.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .i_val (w_mul_next),
    .i_neg (r_neg_res),
    .o_val (w_prod)
  );

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]     r_a;
  logic                 r_divzero;
  logic                 r_neg_rem;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  // Restoring step: {rem, quo} shifts left; a set bit WIDTH in the difference means "restore".
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_mcand};
  assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .i_val (w_div_next[WIDTH-1:0]),
    .i_neg (r_neg_res),
    .o_val (w_quo)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .i_val (w_div_next[2*WIDTH-1:WIDTH]),
    .i_neg (r_neg_rem),
    .o_val (w_rem)
  );
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_a       <= '0;
      r_divzero <= 1'b0;
      r_neg_rem <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (WeHi) r_hi <= WData;
          if (WeLo) r_lo <= WData;
          if (Start) begin
            r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
            r_mcand   <= w_abs_b;
            r_cnt     <= '0;
            r_neg_res <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            if (!Op[1]) begin
              r_state <= MUL;
              r_busy  <= 1'b1;
            end else begin
`ifdef MULDIV_DIV_EN
              r_state   <= DIV;
              r_busy    <= 1'b1;
              r_a       <= A;
              r_divzero <= (B == '0);
              r_neg_rem <= w_signed & A[WIDTH-1];
`else
              r_done    <= 1'b1;
`endif
            end
          end
        end
        MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_hi    <= w_prod[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod[WIDTH-1:0];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            // Divide by zero returns the dividend untouched in HI.
            r_hi    <= r_divzero ? r_a : w_rem;
            r_lo    <= r_divzero ? c_DIVZERO_LO : w_quo;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit
// Rev 1.0
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, WeHi, WeLo;
  logic [1:0]  Op;
  logic [31:0] A, B, WData;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 Clk = ~Clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .WeHi  (WeHi),
    .WeLo  (WeLo),
    .WData (WData),
    .Busy  (Busy),
    .Done  (Done),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; returns the number of Busy cycles seen (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    busy_cycles = 0;
    while (Busy && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic full_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    run_op(op, a, b, n);
    chk({tag, "_busy"}, 64'(n), 64'd32);
    chk({tag, "_done"}, 64'(Done), 64'd1);
    chk({tag, "_hilo"}, {HI, LO}, {exp_hi, exp_lo});
    tick();
    chk({tag, "_done_clr"}, 64'(Done), 64'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b1; Op = c_OP_MULT; A = 32'd9; B = 32'd9;
    WeHi = 1'b0; WeLo = 1'b0; WData = '0;
    tick();
    tick();
    Start = 1'b0;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    Reset = 1'b0;
    tick();
    chk("rst_start_ignored", 64'(Busy), 64'd0);

    full_op("mult_7_m3",   c_OP_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    full_op("multu_max",   c_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    full_op("mult_m5_m6",  c_OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0,         32'h1E);
    full_op("mult_minmin", c_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    full_op("multu_big",   c_OP_MULTU, 32'h8000_0000, 32'd3,         32'h1,         32'h8000_0000);

    // MTHI/MTLO while idle
    WeHi = 1'b1; WData = 32'hAAAA_5555; tick();
    WeHi = 1'b0; WeLo = 1'b1; WData = 32'h5555_AAAA; tick();
    WeLo = 1'b0;
    chk("mthi_mtlo", {HI, LO}, {32'hAAAA_5555, 32'h5555_AAAA});

    // Second Start and WeHi during a busy MULT are ignored
    Op = c_OP_MULTU; A = 32'h0001_0000; B = 32'h0001_0000; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Start = 1'b1; Op = c_OP_MULTU; A = 32'd2; B = 32'd3; WeHi = 1'b1; WData = 32'hDEAD_BEEF;
    tick();
    Start = 1'b0; WeHi = 1'b0;
    chk("busy_hold_hilo", {HI, LO}, {32'hAAAA_5555, 32'h5555_AAAA});
    n = 10;
    while (Busy && n < 40) begin
      n++;
      tick();
    end
    chk("busy_ign_cycles", 64'(n), 64'd32);
    chk("busy_ign_done", 64'(Done), 64'd1);
    chk("busy_ign_hilo", {HI, LO}, {32'h1, 32'h0});
    tick();
    chk("busy_ign_no_restart", 64'(Busy), 64'd0);

    // Start and WeHi together: write lands, completion overwrites
    Op = c_OP_MULTU; A = 32'd6; B = 32'd7; Start = 1'b1; WeHi = 1'b1; WData = 32'hCAFE_F00D;
    tick();
    Start = 1'b0; WeHi = 1'b0;
    chk("start_we_hi", 64'(HI), 64'hCAFE_F00D);
    n = 1;
    while (Busy && n < 40) begin
      n++;
      tick();
    end
    chk("start_we_result", {HI, LO}, {32'h0, 32'd42});

`ifdef MULDIV_DIV_EN
    full_op("div_m7_2",    c_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    full_op("div_7_m2",    c_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD);
    full_op("divu_by0",    c_OP_DIVU, 32'd100,       32'd0,         32'h64,        32'hFFFF_FFFF);
    full_op("div_m5_by0",  c_OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    full_op("div_ovf",     c_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    full_op("divu_max_10", c_OP_DIVU, 32'hFFFF_FFFF, 32'd10,        32'h5,         32'h1999_9999);
    Op = c_OP_DIV; A = 32'd1000; B = 32'd7;
`else
    WeHi = 1'b1; WData = 32'h1234; tick();
    WeHi = 1'b0;
    run_op(c_OP_DIV, 32'd50, 32'd5, n);
    chk("nodiv_busy", 64'(n), 64'd0);
    chk("nodiv_done", 64'(Done), 64'd1);
    chk("nodiv_hi", 64'(HI), 64'h1234);
    tick();
    chk("nodiv_done_clr", 64'(Done), 64'd0);
    Op = c_OP_MULT; A = 32'd1000; B = 32'd7;
`endif

    // Reset at cycle 15 of an operation aborts it
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (14) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hilo", {HI, LO}, 64'd0);
    n = 0;
    repeat (40) begin
      if (Done) n++;
      tick();
    end
    chk("abort_no_done", 64'(n), 64'd0);
    full_op("multu_3_5", c_OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port Clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request a new operation, sampled only when Busy=0.
REQ-005 SHALL have port Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port A  input  32  multiplicand or dividend (rs).
REQ-007 SHALL have port B  input  32  multiplier or divisor (rt).
REQ-008 SHALL have ports WeHi / WeLo  input  1 each  MTHI / MTLO write enables.
REQ-009 SHALL have port WData  input  32  MTHI/MTLO write data.
REQ-010 SHALL have port Busy  output  1  operation in progress; the ID-stage hazard logic stalls on MFHI/MFLO/mult/div while high.
REQ-011 SHALL have port Done  output  1  one-cycle pulse on completion.
REQ-012 SHALL have ports HI / LO  output  32 each  architectural HI/LO registers, fed to the MFHI/MFLO path.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV; IDLE->MUL on Start with Op[1]=0, IDLE->DIV on Start with Op[1]=1, MUL/DIV->IDLE after 32 iterations.
REQ-014 SHALL latch A, B, and Op on the accepting edge N, then run one shift-add (MUL) or restoring-subtract (DIV) iteration per cycle, keeping Busy=1 for exactly 32 cycles.
REQ-015 SHALL write HI/LO and raise Done on edge N+32; Done SHALL be high for the single following cycle, with Busy=0 in that same cycle.
REQ-016 SHALL ignore Start while Busy=1; the in-flight operation continues unaffected.
REQ-017 MULT/MULTU SHALL give a 64-bit product {HI,LO}; the signed op SHALL iterate on magnitudes and negate the result when the operand signs differ.
REQ-018 DIV/DIVU SHALL give LO=quotient and HI=remainder; for the signed op the quotient sign is sign(A) XOR sign(B), the remainder takes the sign of A, and truncation is toward zero.
REQ-019 Divide by zero (B=0) SHALL complete normally with HI=A and LO=32'hFFFFFFFF.
REQ-020 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-021 WeHi/WeLo SHALL write WData into HI/LO on the next edge only when Busy=0; they are ignored while Busy=1.
REQ-022 When Start and WeHi/WeLo arrive together in IDLE, the write SHALL take effect and the completion SHALL later overwrite both HI and LO.
REQ-023 HI/LO SHALL hold their values during an operation until the completion edge.

Reset
REQ-024 Reset=1 at any edge, including mid-operation, SHALL abort the operation and set state=IDLE, Busy=0, Done=0, HI=0, LO=0, and the iteration counter to 0.
REQ-025 Start asserted together with Reset SHALL be ignored.

Configuration
REQ-026 Macro MULDIV_DIV_EN SHALL, when defined, compile in the divide datapath and the DIV state.
REQ-027 Without MULDIV_DIV_EN, DIV/DIVU SHALL be accepted, Busy SHALL stay 0, Done SHALL pulse in the next cycle, HI/LO SHALL stay unchanged, and multiply SHALL behave identically.

Structure
REQ-028 Package muldiv_pkg SHALL hold the Op encodings, the state enum, the iteration count (32), and the divide-by-zero LO constant.
REQ-029 Sub-module muldiv_signfix SHALL perform the combinational abs-in / conditional-negate-out sign correction, instantiated once per operand/result path.

Verification
REQ-030 MULT A=7, B=32'hFFFFFFFD -> after 32 Busy cycles, Done pulses and HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-031 MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-032 DIV A=32'hFFFFFFF9 (-7), B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU A=100, B=0 -> HI=32'h64, LO=32'hFFFFFFFF.
REQ-033 Start a MULT, assert a second Start and WeHi at cycle 10 -> both ignored, and the first result is written at edge N+32.
REQ-034 Reset at cycle 15 of a DIV -> next cycle Busy=0, HI=LO=0, and Done never pulses; a new MULTU 3*5 then gives LO=15, HI=0.
REQ-035 Build without MULDIV_DIV_EN, preload HI=32'h1234 via WeHi, issue DIV -> Done pulses one cycle later and HI stays 32'h1234.
